// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with registered active-low grants and one idle cycle between owners.
// Optional tenure limit with forced preemption is enabled by defining TENURE_LIMIT_EN.
module rr_bus_arbiter #(
    parameter int NREQ       = 2,
    parameter int IDW        = 1,
    parameter int MAX_TENURE = 16,
    parameter int TCW        = 5
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic [NREQ-1:0] breq_,
    output logic [NREQ-1:0] bgrt_,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id,
    output logic            preempt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_PREEMPT = 2'd2
    } state_t;

    if ((NREQ < 2) || (IDW != $clog2(NREQ)) || (MAX_TENURE < 2) || ((2 ** TCW) <= MAX_TENURE)) begin : g_bad_params
        $error("rr_bus_arbiter: inconsistent parameters");
    end

    // Returns {found, index} of the first set request after 'last', wrapping modulo NREQ.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] req, input logic [IDW-1:0] last);
        logic [IDW:0] res;
        int unsigned  idx;
        res = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = (int'(last) + off) % NREQ;
            res = req[idx] ? {1'b1, IDW'(idx)} : res;
        end
        return res;
    endfunction

    state_t          state_r, state_s;
    logic [IDW-1:0]  ptr_r, ptr_s;
    logic [NREQ-1:0] bgrt_r, bgrt_s;
    logic            gnt_valid_r, gnt_valid_s;
    logic [IDW-1:0]  gnt_id_r, gnt_id_s;
    logic [NREQ-1:0] req_s;
    logic [NREQ-1:0] owner_mask_s;
    logic [NREQ-1:0] arb_req_s;
    logic [IDW:0]    pick_s;
    logic            owner_req_s;
`ifdef TENURE_LIMIT_EN
    logic [TCW-1:0]  cnt_r, cnt_s;
    logic            preempt_r, preempt_s;
    logic            other_req_s;
`endif

    assign req_s        = ~breq_;
    assign owner_mask_s = NREQ'(1) << gnt_id_r;
    assign owner_req_s  = |(req_s & owner_mask_s);
    // The previous owner sits out the arbitration that follows its preemption.
    assign arb_req_s    = (state_r == ST_PREEMPT) ? (req_s & ~owner_mask_s) : req_s;
    assign pick_s       = rr_pick(arb_req_s, ptr_r);
`ifdef TENURE_LIMIT_EN
    assign other_req_s  = |(req_s & ~owner_mask_s);
`endif

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        bgrt_s      = '1;
        gnt_valid_s = 1'b0;
        gnt_id_s    = gnt_id_r;
`ifdef TENURE_LIMIT_EN
        cnt_s       = cnt_r;
        preempt_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE, ST_PREEMPT: begin
                if (pick_s[IDW]) begin
                    bgrt_s      = ~(NREQ'(1) << pick_s[IDW-1:0]);
                    gnt_valid_s = 1'b1;
                    gnt_id_s    = pick_s[IDW-1:0];
                    ptr_s       = pick_s[IDW-1:0];
`ifdef TENURE_LIMIT_EN
                    cnt_s       = '0;
`endif
                    state_s     = ST_GRANT;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!owner_req_s) begin
                    state_s = ST_IDLE;
                end
`ifdef TENURE_LIMIT_EN
                else if ((cnt_r == TCW'(MAX_TENURE - 1)) && other_req_s) begin
                    state_s   = ST_PREEMPT;
                    ptr_s     = gnt_id_r;
                    preempt_s = 1'b1;
                end
`endif
                else begin
                    bgrt_s      = bgrt_r;
                    gnt_valid_s = 1'b1;
`ifdef TENURE_LIMIT_EN
                    if (cnt_r != TCW'(MAX_TENURE - 1)) begin
                        cnt_s = cnt_r + TCW'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
`endif
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset forces the bus released immediately.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_r     <= ST_IDLE;
            ptr_r       <= IDW'(NREQ - 1);
            bgrt_r      <= '1;
            gnt_valid_r <= 1'b0;
            gnt_id_r    <= '0;
`ifdef TENURE_LIMIT_EN
            cnt_r       <= '0;
            preempt_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            bgrt_r      <= bgrt_s;
            gnt_valid_r <= gnt_valid_s;
            gnt_id_r    <= gnt_id_s;
`ifdef TENURE_LIMIT_EN
            cnt_r       <= cnt_s;
            preempt_r   <= preempt_s;
`endif
        end
    end

    assign bgrt_     = bgrt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_id    = gnt_id_r;
`ifdef TENURE_LIMIT_EN
    assign preempt   = preempt_r;
`else
    assign preempt   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed self-checking bench for rr_bus_arbiter (two masters, MAX_TENURE = 4).
module tb_rr_bus_arbiter;

    logic       clk;
    logic       reset_;
    logic [1:0] breq_;
    logic [1:0] bgrt_;
    logic       gnt_valid;
    logic [0:0] gnt_id;
    logic       preempt;

    int checks;
    int errors;

    rr_bus_arbiter #(
        .NREQ(2),
        .IDW(1),
        .MAX_TENURE(4),
        .TCW(3)
    ) dut (
        .clk(clk),
        .reset_(reset_),
        .breq_(breq_),
        .bgrt_(bgrt_),
        .gnt_valid(gnt_valid),
        .gnt_id(gnt_id),
        .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At most one grant line may be low at any time.
    always @(negedge clk) begin
        assert ($countones(~bgrt_) <= 1)
        else begin
            errors++;
            $display("FAIL onehot_grant: bgrt_=%b required at most one low bit", bgrt_);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset_ = 1'b0;
        breq_  = 2'b11;
        tick();
        reset_ = 1'b1;
    endtask

    task automatic test_reset;
        reset_ = 1'b1;
        breq_  = 2'b11;
        #1;
        reset_ = 1'b0;
        #2;
        checks++;
        if (bgrt_ !== 2'b11) begin errors++; $display("FAIL reset_bgrt: got %b required 11", bgrt_); end
        checks++;
        if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", gnt_valid); end
        checks++;
        if (gnt_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %b required 0", gnt_id); end
        checks++;
        if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b required 0", preempt); end
        tick();
        reset_ = 1'b1;
        tick();
        checks++;
        if (bgrt_ !== 2'b11) begin errors++; $display("FAIL idle_after_reset: got %b required 11", bgrt_); end
    endtask

    task automatic test_single_master;
        apply_reset();
        breq_ = 2'b01;
        tick();
        checks++;
        if (bgrt_ !== 2'b01 || gnt_id !== 1'b1 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got bgrt_=%b id=%b valid=%b required 01/1/1", bgrt_, gnt_id, gnt_valid);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bgrt_ !== 2'b01) begin errors++; $display("FAIL single_hold[%0d]: got %b required 01", i, bgrt_); end
        end
        breq_ = 2'b11;
        tick();
        checks++;
        if (bgrt_ !== 2'b11 || gnt_valid !== 1'b0 || gnt_id !== 1'b1) begin
            errors++;
            $display("FAIL single_release: got bgrt_=%b valid=%b id=%b required 11/0/1", bgrt_, gnt_valid, gnt_id);
        end
    endtask

    task automatic test_round_robin;
        apply_reset();
        breq_ = 2'b00;
        tick();
        checks++;
        if (bgrt_ !== 2'b10 || gnt_id !== 1'b0) begin errors++; $display("FAIL rr_first: got %b id=%b required 10/0", bgrt_, gnt_id); end
        breq_ = 2'b01;
        tick();
        checks++;
        if (bgrt_ !== 2'b11) begin errors++; $display("FAIL rr_dead1: got %b required 11", bgrt_); end
        tick();
        checks++;
        if (bgrt_ !== 2'b01 || gnt_id !== 1'b1) begin errors++; $display("FAIL rr_second: got %b id=%b required 01/1", bgrt_, gnt_id); end
        breq_ = 2'b00;
        tick();
        checks++;
        if (bgrt_ !== 2'b01) begin errors++; $display("FAIL rr_nonowner: got %b required 01", bgrt_); end
        breq_ = 2'b10;
        tick();
        checks++;
        if (bgrt_ !== 2'b11) begin errors++; $display("FAIL rr_dead2: got %b required 11", bgrt_); end
        tick();
        checks++;
        if (bgrt_ !== 2'b10 || gnt_id !== 1'b0) begin errors++; $display("FAIL rr_regrant: got %b id=%b required 10/0", bgrt_, gnt_id); end
        breq_ = 2'b11;
        tick();
    endtask

    task automatic test_contention;
        logic [1:0] exp_bgrt;
        logic       exp_pre;
        apply_reset();
        breq_ = 2'b00;
`ifdef TENURE_LIMIT_EN
        for (int i = 0; i < 20; i++) begin
            tick();
            case (i % 10)
                0, 1, 2, 3: begin exp_bgrt = 2'b10; exp_pre = 1'b0; end
                5, 6, 7, 8: begin exp_bgrt = 2'b01; exp_pre = 1'b0; end
                default:    begin exp_bgrt = 2'b11; exp_pre = 1'b1; end
            endcase
            checks++;
            if (bgrt_ !== exp_bgrt || preempt !== exp_pre) begin
                errors++;
                $display("FAIL tenure[%0d]: got bgrt_=%b preempt=%b required %b/%b", i, bgrt_, preempt, exp_bgrt, exp_pre);
            end
        end
`else
        exp_bgrt = 2'b10;
        exp_pre  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (bgrt_ !== exp_bgrt || preempt !== exp_pre) begin
                errors++;
                $display("FAIL hold_forever[%0d]: got bgrt_=%b preempt=%b required %b/%b", i, bgrt_, preempt, exp_bgrt, exp_pre);
            end
        end
`endif
        breq_ = 2'b11;
        tick();
    endtask

    task automatic test_release_at_limit;
        apply_reset();
        breq_ = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bgrt_ !== 2'b10) begin errors++; $display("FAIL limit_owner: got %b required 10", bgrt_); end
        breq_ = 2'b01;
        tick();
        checks++;
        if (bgrt_ !== 2'b11 || preempt !== 1'b0) begin
            errors++;
            $display("FAIL limit_release: got bgrt_=%b preempt=%b required 11/0", bgrt_, preempt);
        end
        tick();
        checks++;
        if (bgrt_ !== 2'b01) begin errors++; $display("FAIL limit_next: got %b required 01", bgrt_); end
        breq_ = 2'b11;
        tick();
    endtask

    task automatic test_reset_mid_grant;
        apply_reset();
        breq_ = 2'b01;
        tick();
        tick();
        checks++;
        if (bgrt_ !== 2'b01) begin errors++; $display("FAIL midrst_setup: got %b required 01", bgrt_); end
        #3;
        reset_ = 1'b0;
        #1;
        checks++;
        if (bgrt_ !== 2'b11 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got bgrt_=%b valid=%b required 11/0", bgrt_, gnt_valid);
        end
        breq_ = 2'b00;
        tick();
        reset_ = 1'b1;
        tick();
        checks++;
        if (bgrt_ !== 2'b10 || gnt_id !== 1'b0) begin errors++; $display("FAIL midrst_first: got %b id=%b required 10/0", bgrt_, gnt_id); end
        breq_ = 2'b11;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_master();
        test_round_robin();
        test_contention();
        test_release_at_limit();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
